// File: rtl/aes_pkg.sv
// AES shared definitions: key-schedule FSM states, Rcon table, forward S-box.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TAB[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_sub_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word.
// Latency: combinational. Backpressure: n/a.
module sub_word (
  input  logic [31:0] word,
  output logic [31:0] subst
);
  import aes_pkg::*;

  assign subst = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: round 10 key in, round keys 10..0 out. Macro AES_INVKS_SUBWORD_REG_EN registers SubWord.
// Latency: first key 1 cycle after start; 1 key/cycle (2 cycles/key with the macro).
// Backpressure: rk_out/rk_round hold while rk_valid & !rk_ready.
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);
  import aes_pkg::*;

  state_t        state_q, state_d;
  logic [127:0]  key_q;
  logic [3:0]    round_q;
  logic          done_q;
  logic          hs;
  logic [31:0]   wa, wb, wc, wd;
  logic [31:0]   d_prev, sw_out, sw_sel;
  logic [7:0]    rc;
  logic [127:0]  key_nxt;

  assign {wa, wb, wc, wd} = key_q;
  assign hs     = (state_q == ST_SHOW) && rk_ready;
  assign d_prev = wd ^ wc;

  sub_word u_sub_word (
    .word  ({d_prev[23:0], d_prev[31:24]}),
    .subst (sw_out)
  );

`ifdef AES_INVKS_SUBWORD_REG_EN
  logic [31:0] sw_q;

  // round_q is already decremented in CALC, so Rcon uses the round being left.
  assign sw_sel = sw_q;
  assign rc     = rcon(round_q + 4'd1);
`else
  assign sw_sel = sw_out;
  assign rc     = rcon(round_q);
`endif

  assign key_nxt = {wa ^ sw_sel ^ {rc, 24'h0}, wa ^ wb, wb ^ wc, d_prev};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SHOW;
      ST_SHOW: begin
        if (rk_ready) begin
          if (round_q == 4'd0) state_d = ST_IDLE;
`ifdef AES_INVKS_SUBWORD_REG_EN
          else                 state_d = ST_CALC;
`else
          else                 state_d = ST_SHOW;
`endif
        end
      end
      ST_CALC: state_d = ST_SHOW;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef AES_INVKS_SUBWORD_REG_EN
      sw_q    <= '0;
`endif
    end else begin
      done_q <= hs && (round_q == 4'd0);
      if (state_q == ST_IDLE && start) begin
        key_q   <= key_in;
        round_q <= 4'd10;
      end
      if (hs && round_q != 4'd0) begin
        round_q <= round_q - 4'd1;
`ifdef AES_INVKS_SUBWORD_REG_EN
        sw_q    <= sw_out;
`else
        key_q   <= key_nxt;
`endif
      end
`ifdef AES_INVKS_SUBWORD_REG_EN
      if (state_q == ST_CALC) key_q <= key_nxt;
`endif
    end
  end

  always_comb begin
    rk_valid = (state_q == ST_SHOW);
    busy     = (state_q != ST_IDLE);
  end

  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign done     = done_q;

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Sequential AES-128 inverse key-schedule generator for the decryption datapath. Loaded with the final (round-10) round key, it emits round keys in reverse order (round 10 down to round 0), one per valid/ready beat, by inverting the forward expansion recurrence. It sits between key storage and the inverse-cipher round logic. It reuses the same RotWord/SubWord word transforms as forward key expansion.

## Interface
- No parameters. Key size is fixed at AES-128: 4 words, 11 round keys.
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; honoured only in IDLE.
- key_in  in  128  round-10 key. word0 = [127:96] … word3 = [31:0]. Sampled when start is honoured.
- rk_out  out  128  current round key, same word order as key_in.
- rk_round  out  4  round index of rk_out, 10 down to 0.
- rk_valid  out  1  rk_out/rk_round valid.
- rk_ready  in  1  consumer accepts the current key.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, SHOW, CALC. CALC is reachable only with the macro defined.
- IDLE:
  - start=1 → load key_in into the key register; rk_round←10; go to SHOW.
- SHOW:
  - rk_valid=1. rk_out and rk_round are held stable until the handshake (rk_valid & rk_ready).
  - Handshake with rk_round>0 → compute the previous key; rk_round←rk_round-1; go to SHOW (macro off) or CALC (macro on).
  - Handshake with rk_round==0 → go to IDLE, done=1 for that next cycle.
- Inverse recurrence, with current key = {a,b,c,d} for round r and previous key = {a',b',c',d'}:
  - d' = d ^ c
  - c' = c ^ b
  - b' = b ^ a
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[r],24'h0}
  - RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord applies the forward S-box to each byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- start outside IDLE is ignored. No effect on the key register or rk_round.
- rk_ready while rk_valid=0 is ignored.
- rst in any state → IDLE next cycle; all outputs 0; key register cleared. Any in-progress sequence is abandoned with no done pulse.
- Reset values: rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0.

## Timing
- start at cycle t → rk_valid=1, rk_round=10, rk_out=key_in at t+1.
- Macro off:
  - Handshake at cycle t → next key valid at t+1.
  - Throughput is 1 key/cycle with rk_ready held high.
  - Full sequence: 11 cycles of valid; done at the cycle after the round-0 accept.
- Macro on:
  - Handshake at t → CALC at t+1 (rk_valid=0) → SHOW at t+2.
  - Throughput is 1 key per 2 cycles.
- done and rk_valid are never high in the same cycle.
- busy is high from t+1 after start through the cycle of the round-0 accept.

## Configuration
- AES_INVKS_SUBWORD_REG_EN:
  - Defined: SubWord output is registered. The round-key update takes effect in CALC. Shortens the critical path through d'→S-box→a'.
  - Undefined: the update is fully combinational in one cycle and CALC is never entered.
- Key values produced are identical either way; only cycle counts differ.

## Structure
- Shared aes_pkg holds:
  - Rcon table/function indexed by round.
  - State encodings (IDLE, SHOW, CALC).
  - S-box function, shared with forward key expansion and SubBytes.
- Sub-module sub_word: 32-bit combinational, four S-box lookups. Instantiated once.
- RotWord is inlined as a concatenation.

## Test plan
- FIPS-197 A.1 sequence, rk_ready tied 1:
  - start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 → rounds 10..0.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses once, 1 cycle after the round-0 accept.
- Backpressure: rk_ready low for 5 cycles at round 7 → rk_out/rk_round held constant, rk_valid stays 1. Sequence then resumes correctly.
- start while busy (at round 5) → ignored; remaining keys match A.1; no restart.
- rst asserted at round 4 → next cycle all outputs 0, state IDLE, no done pulse. A subsequent start reproduces the full sequence.
- Back-to-back: start asserted the cycle done pulses → accepted; round 10 is valid the next cycle.
- Macro on: same A.1 vectors. rk_valid low every other cycle; 21 cycles from first valid to the round-0 accept.
